// File: rtl/twiddle_pkg.sv
// twiddle_pkg -- shared definitions for the twiddle-factor generator.
//   Q0..Q3             : quadrant codes taken from the top two index bits.
//   rom_depth()        : quarter-wave table depth, N/4 + 1 words.
//   quarter_sin_value(): one table word, round-half-away and saturated so
//                        that negating it never overflows.
package twiddle_pkg;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam real PI = 3.14159265358979323846;

    function automatic int rom_depth(input int awl);
        return (1 << (awl - 2)) + 1;
    endfunction

    // sin(2*pi*m/2^awl) scaled by a*2^(dwl-1). The angle never leaves
    // [0, pi/2], where a 12-term Taylor series is far below one LSB of error.
    function automatic int quarter_sin_value(input int m, input int awl,
                                             input int dwl, input real a);
        real x;
        real term;
        real s;
        real v;
        int  full_scale;
        x    = 2.0 * PI * real'(m) / real'(1 << awl);
        term = x;
        s    = x;
        for (int i = 1; i < 12; i++) begin
            term = -term * x * x / real'((2 * i) * (2 * i + 1));
            s    = s + term;
        end
        full_scale = 1 << (dwl - 1);
        // Values are non-negative, so +0.5 then truncate is round-half-away.
        v = a * s * real'(full_scale) + 0.5;
        if (v >= real'(full_scale)) return full_scale - 1;
        if (v < 0.0) return 0;
        return $rtoi(v);
    endfunction

endpackage

// File: rtl/quarter_sin_rom.sv
// quarter_sin_rom -- dual-read synchronous quarter-wave sine ROM.
//   clk, rst_n      : clock, asynchronous active-low reset (outputs clear to 0)
//   en              : capture both reads this cycle, otherwise hold
//   addr_a, addr_b  : word addresses 0..N/4
//   neg_a, neg_b    : negate the corresponding word before it is registered
//   data_a, data_b  : registered signed words
module quarter_sin_rom
    import twiddle_pkg::*;
#(
    parameter int  DWL = 16,
    parameter int  AWL = 10,
    parameter real A   = 1.0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [AWL-2:0] addr_a,
    input  logic [AWL-2:0] addr_b,
    input  logic           neg_a,
    input  logic           neg_b,
    output logic [DWL-1:0] data_a,
    output logic [DWL-1:0] data_b
);

    localparam int DEPTH = rom_depth(AWL);

    logic [DWL-1:0] rom_w [DEPTH];
    logic [DWL-1:0] word_a;
    logic [DWL-1:0] word_b;
    logic [DWL-1:0] data_a_d, data_a_q;
    logic [DWL-1:0] data_b_d, data_b_q;

    // Constant table; folds to fixed contents in synthesis.
    always_comb begin
        for (int m = 0; m < DEPTH; m++) begin
            rom_w[m] = DWL'(quarter_sin_value(m, AWL, DWL, A));
        end
    end

    always_comb begin
        word_a   = rom_w[addr_a];
        word_b   = rom_w[addr_b];
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (en) begin
            data_a_d = neg_a ? -word_a : word_a;
            data_b_d = neg_b ? -word_b : word_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign data_a = data_a_q;
    assign data_b = data_b_q;

endmodule

// File: rtl/twiddle_rom_unit.sv
// twiddle_rom_unit -- pipelined twiddle generator, W_N^k = cos - j*sin,
// N = 2^AWL, rebuilt from a quarter-wave sine table by quadrant folding.
//   i_CLK, i_RESET_N  : clock, asynchronous active-low reset
//   i_VALID/o_READY   : index request handshake, i_ADDR = k
//   o_VALID/i_READY   : result handshake, o_RE = cos, o_IM = -sin (signed)
//   i_INV             : present only with TWIDDLE_INVERSE_EN; selects the
//                       conjugate (o_IM = +sin) for the inverse transform.
// Stage 1 holds the fold addresses and sign bits, stage 2 is the ROM read
// register; two cycles from accept to o_VALID, one pair per cycle.
module twiddle_rom_unit
    import twiddle_pkg::*;
#(
    parameter int  DWL = 16,
    parameter int  AWL = 10,
    parameter real A   = 1.0
) (
    input  logic           i_CLK,
    input  logic           i_RESET_N,
    input  logic           i_VALID,
    output logic           o_READY,
    input  logic [AWL-1:0] i_ADDR,
`ifdef TWIDDLE_INVERSE_EN
    input  logic           i_INV,
`endif
    output logic           o_VALID,
    input  logic           i_READY,
    output logic [DWL-1:0] o_RE,
    output logic [DWL-1:0] o_IM
);

    if (AWL < 3) begin : g_awl_check
        $error("twiddle_rom_unit: AWL must be >= 3");
    end
    if (A <= 0.0 || A > 1.0) begin : g_amp_check
        $error("twiddle_rom_unit: A must lie in (0, 1]");
    end

    localparam int             RW    = AWL - 2;
    localparam logic [AWL-2:0] M_IDX = {1'b1, {RW{1'b0}}};

    logic inv;
`ifdef TWIDDLE_INVERSE_EN
    assign inv = i_INV;
`else
    assign inv = 1'b0;
`endif

    logic [2:1]     vld_pipe_d, vld_pipe_q;
    logic [AWL-2:0] cos_idx_d, cos_idx_q;
    logic [AWL-2:0] sin_idx_d, sin_idx_q;
    logic           re_neg_d, re_neg_q;
    logic           im_neg_d, im_neg_q;

    logic [1:0]     quad;
    logic [AWL-2:0] idx_r;
    logic [AWL-2:0] idx_mr;
    logic           sin_neg;
    logic           s1_adv;
    logic           s2_adv;
    logic           accept;

    assign quad   = i_ADDR[AWL-1 -: 2];
    assign idx_r  = {1'b0, i_ADDR[RW-1:0]};
    assign idx_mr = M_IDX - idx_r;

    always_comb begin
        s2_adv     = !vld_pipe_q[2] || i_READY;
        s1_adv     = !vld_pipe_q[1] || s2_adv;
        accept     = i_VALID && s1_adv;

        vld_pipe_d = vld_pipe_q;
        cos_idx_d  = cos_idx_q;
        sin_idx_d  = sin_idx_q;
        re_neg_d   = re_neg_q;
        im_neg_d   = im_neg_q;
        sin_neg    = 1'b0;

        if (s2_adv) vld_pipe_d[2] = vld_pipe_q[1];
        if (s1_adv) vld_pipe_d[1] = i_VALID;

        if (accept) begin
            // Odd quadrants swap which fold index feeds sin and cos.
            if (quad[0]) begin
                sin_idx_d = idx_mr;
                cos_idx_d = idx_r;
            end else begin
                sin_idx_d = idx_r;
                cos_idx_d = idx_mr;
            end
            unique case (quad)
                Q0: begin re_neg_d = 1'b0; sin_neg = 1'b0; end
                Q1: begin re_neg_d = 1'b1; sin_neg = 1'b0; end
                Q2: begin re_neg_d = 1'b1; sin_neg = 1'b1; end
                Q3: begin re_neg_d = 1'b0; sin_neg = 1'b1; end
            endcase
            // Forward output is -sin; the conjugate keeps the sin sign.
            im_neg_d = ~sin_neg ^ inv;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            vld_pipe_q <= '0;
            cos_idx_q  <= '0;
            sin_idx_q  <= '0;
            re_neg_q   <= 1'b0;
            im_neg_q   <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            cos_idx_q  <= cos_idx_d;
            sin_idx_q  <= sin_idx_d;
            re_neg_q   <= re_neg_d;
            im_neg_q   <= im_neg_d;
        end
    end

    quarter_sin_rom #(
        .DWL (DWL),
        .AWL (AWL),
        .A   (A)
    ) u_rom (
        .clk    (i_CLK),
        .rst_n  (i_RESET_N),
        .en     (s2_adv && vld_pipe_q[1]),
        .addr_a (cos_idx_q),
        .addr_b (sin_idx_q),
        .neg_a  (re_neg_q),
        .neg_b  (im_neg_q),
        .data_a (o_RE),
        .data_b (o_IM)
    );

    assign o_READY = s1_adv;
    assign o_VALID = vld_pipe_q[2];

endmodule

// File: tb/tb_twiddle_rom_unit.sv
module tb_twiddle_rom_unit;

    localparam int DWL = 8;
    localparam int AWL = 4;
    localparam real PI = 3.14159265358979323846;

    // Expected forward twiddles for N=16, Q = {0,49,91,118,127}.
    localparam int EXP_RE [16] = '{127, 118, 91, 49, 0, -49, -91, -118,
                                   -127, -118, -91, -49, 0, 49, 91, 118};
    localparam int EXP_IM [16] = '{0, -49, -91, -118, -127, -118, -91, -49,
                                   0, 49, 91, 118, 127, 118, 91, 49};
    localparam int DIR_K [6] = '{0, 2, 4, 5, 10, 15};

    typedef struct {
        int re;
        int im;
        int k;
        bit inv;
        int hs;
        bit lat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_valid = 1'b0;
    logic           i_ready = 1'b1;
    logic           i_inv = 1'b0;
    logic [AWL-1:0] i_addr = '0;
    logic           o_ready;
    logic           o_valid;
    logic [DWL-1:0] o_re;
    logic [DWL-1:0] o_im;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_en = 1'b0;

    twiddle_rom_unit #(
        .DWL (DWL),
        .AWL (AWL),
        .A   (1.0)
    ) dut (
        .i_CLK     (clk),
        .i_RESET_N (rst_n),
        .i_VALID   (i_valid),
        .o_READY   (o_ready),
        .i_ADDR    (i_addr),
`ifdef TWIDDLE_INVERSE_EN
        .i_INV     (i_inv),
`endif
        .o_VALID   (o_valid),
        .i_READY   (i_ready),
        .o_RE      (o_re),
        .o_IM      (o_im)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic real rabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    // Scoreboard consumer: pops on every output handshake.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            chk("sb_empty_on_out", int'(sb.size() == 0), 0);
            if (sb.size() != 0) begin
                int  re;
                int  im;
                real ang;
                real mre;
                real mim;
                mon_e = sb.pop_front();
                re = int'($signed(o_re));
                im = int'($signed(o_im));
                chk($sformatf("re_k%0d", mon_e.k), re, mon_e.re);
                chk($sformatf("im_k%0d", mon_e.k), im, mon_e.im);
                if (mon_e.lat) chk($sformatf("latency_k%0d", mon_e.k), cyc - mon_e.hs, 2);
                ang = 2.0 * PI * real'(mon_e.k) / 16.0;
                mre = 128.0 * $cos(ang);
                mim = (mon_e.inv ? 128.0 : -128.0) * $sin(ang);
                chk($sformatf("model_k%0d", mon_e.k),
                    int'(rabs(real'(re) - mre) <= 1.0 && rabs(real'(im) - mim) <= 1.0
                         && re <= 127 && re >= -127 && im <= 127 && im >= -127), 1);
            end
        end
    end

    task automatic send(input int k, input bit inv);
        exp_t e;
        int   n;
        i_valid = 1'b1;
        i_addr  = k[AWL-1:0];
        i_inv   = inv;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", int'(o_ready), 1);
        e.re  = EXP_RE[k];
        e.im  = inv ? -EXP_IM[k] : EXP_IM[k];
        e.k   = k;
        e.inv = inv;
        e.hs  = cyc;
        e.lat = lat_en;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_re", int'(o_re), 0);
        chk("rst_im", int'(o_im), 0);
        chk("rst_ready", int'(o_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed forward points, continuous stream
        lat_en = 1'b1;
        for (int i = 0; i < 6; i++) send(DIR_K[i], 1'b0);
        idle(1);
        drain();

        // Backpressure: freeze on k=1 for three cycles
        lat_en = 1'b0;
        send(1, 1'b0);
        send(2, 1'b0);
        chk("bp_first_valid", int'(o_valid), 1);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_addr  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(o_valid), 1);
            chk("bp_re", int'($signed(o_re)), 118);
            chk("bp_im", int'($signed(o_im)), -49);
            chk("bp_ready", int'(o_ready), 0);
            @(posedge clk);
            #1;
        end
        i_ready = 1'b1;
        send(3, 1'b0);
        idle(1);
        drain();
        idle(2);
        chk("bp_no_extra", int'(o_valid), 0);

        // Reset with both stages full
        i_ready = 1'b0;
        send(5, 1'b0);
        send(6, 1'b0);
        i_valid = 1'b0;
        chk("pre_rst_valid", int'(o_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_re", int'(o_re), 0);
        chk("mid_rst_im", int'(o_im), 0);
        sb.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_ready", int'(o_ready), 1);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        lat_en  = 1'b1;
        send(8, 1'b0);
        idle(2);
        drain();

        // Full-period sweep
        for (int k = 0; k < 16; k++) send(k, 1'b0);
        idle(1);
        drain();

`ifdef TWIDDLE_INVERSE_EN
        // Conjugate then forward on the same index, back to back
        send(4, 1'b1);
        send(4, 1'b0);
        idle(1);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/twiddle_rom_unit.md
Name: twiddle_rom_unit

Overview:
- Registered, pipelined twiddle-factor generator for the iterative FFT: for index k returns W_N^k = cos(2πk/N) − j·sin(2πk/N), N = 2^AWL.
- Stores only a quarter-wave sine table (N/4+1 entries) and rebuilds both components by quadrant folding and sign control.
- Sits between the FFT address generator and the butterfly unit, with a valid/ready handshake and backpressure.

Parameters:
- DWL, 16, signed output word length (two's complement, Q1.(DWL−1)).
- AWL, 10, index width; full period N = 2^AWL points; AWL ≥ 3 (elaboration error otherwise).
- A, 1.0, real amplitude, 0 < A ≤ 1.0.

Ports:
- i_CLK  in  1  clock, rising edge.
- i_RESET_N  in  1  asynchronous active-low reset.
- i_VALID  in  1  index request valid.
- o_READY  out  1  block accepts a request this cycle.
- i_ADDR  in  AWL  twiddle index k.
- o_VALID  out  1  output pair valid.
- i_READY  in  1  downstream accepts the output pair.
- o_RE  out  DWL  cos(2πk/N)·A, signed.
- o_IM  out  DWL  −sin(2πk/N)·A, signed.

Behaviour:
- Table: Q[m] = round-half-away(A·sin(2πm/N)·2^(DWL−1)), m = 0..N/4, computed at elaboration. Any value ≥ 2^(DWL−1) saturates to 2^(DWL−1)−1, so negation never overflows.
- Decode: q = k[AWL−1:AWL−2], r = k[AWL−3:0], M = N/4.
  - sin: q0 +Q[r], q1 +Q[M−r], q2 −Q[r], q3 −Q[M−r].
  - cos: q0 +Q[M−r], q1 −Q[r], q2 −Q[M−r], q3 +Q[r].
  - o_RE = cos, o_IM = −sin.
- Pipeline: S1 registers the fold indices r and M−r plus two sign bits; S2 registers the ROM reads with signs applied into o_RE/o_IM. Latency is exactly 2 cycles from handshake (i_VALID & o_READY) to o_VALID, with no bubbles.
- Backpressure:
  - S2 advances when !o_VALID | i_READY.
  - S1 advances when S1 is empty or S2 advances.
  - o_READY = !S1_valid | S2 advances (combinational from i_READY; no combinational path from i_VALID).
- Stall: while o_VALID & !i_READY, o_RE/o_IM/o_VALID hold stable, and S1 holds its request.
- Simultaneous accept and output handshake in the same cycle: both take effect; throughput 1 pair/cycle.
- Reset (asynchronous, any time): both stage valids → 0, o_VALID = 0, o_RE = 0, o_IM = 0, o_READY = 1 on the next cycle. In-flight requests are discarded, not replayed.
- Boundaries:
  - r = 0 in q1/q3 selects Q[M]; k = N/4 gives o_RE = 0 and o_IM = −(2^(DWL−1)−1).
  - k = N−1 wraps correctly to q3.

Optional Feature:
- Macro TWIDDLE_INVERSE_EN.
- Defined: adds input i_INV (1 bit), sampled with i_ADDR at the handshake and pipelined alongside the request. When i_INV = 1 the output is the conjugate (o_IM = +sin), for IFFT.
- Not defined: the port is absent and the output is always the forward twiddle.

Decomposition:
- Package twiddle_pkg:
  - quadrant encoding localparams Q0..Q3;
  - function quarter_sin_value(m, AWL, DWL, A) returning the saturated, rounded integer;
  - localparam helper for table depth N/4+1.
- Sub-module quarter_sin_rom: dual-read synchronous ROM of N/4+1 words (addresses r and M−r), initialised from quarter_sin_value. twiddle_rom_unit holds the handshake, fold and sign logic.

Test Plan (DWL=8, AWL=4, A=1.0; Q = {0, 49, 91, 118, 127}):
- Forward sweep, continuous valid, i_READY=1:
  - k=0 → RE=127, IM=0;
  - k=2 → RE=91, IM=−91 (0xA5);
  - k=4 → RE=0, IM=−127 (0x81);
  - k=5 → RE=−49 (0xCF), IM=−118 (0x8A);
  - k=10 → RE=−91, IM=+91;
  - k=15 → RE=118, IM=+49.
  - Each result appears exactly 2 cycles after its handshake.
- Backpressure: stream k=1,2,3 and hold i_READY=0 for 3 cycles after the first o_VALID → o_VALID stays 1, output frozen at k=1 (RE=118, IM=−49), o_READY=0 once the pipe is full; after release k=1,2,3 emerge in order with no loss or duplication.
- Reset mid-stream: assert i_RESET_N=0 while both stages are valid → o_VALID, o_RE, o_IM go to 0 immediately (asynchronously); after release the first new request k=8 → RE=−127, IM=0 after 2 cycles.
- Full-period sweep k=0..15 against a real-valued model → every |error| ≤ 1 LSB; all 16 outputs within ±127.
- TWIDDLE_INVERSE_EN defined: k=4 with i_INV=1 → RE=0, IM=+127; same k with i_INV=0 in the next cycle → IM=−127.
